// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage interlock and forwarding controller.
// Compares decode sources with in-flight EX/MEM destinations to produce operand
// forward selects and freeze/bubble requests. It also times the multi-cycle
// MULT/DIV unit that guards HI/LO and keeps a saturating stall counter.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_branch,
    input  logic             id_hilo_use,
    input  logic             ex_wr,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_md_start,
    input  logic             ex_md_div,
    input  logic             mem_wr,
    input  logic [4:0]       mem_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_CYCLES);
    localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_CYCLES);
    localparam logic [MD_W-1:0] MD_LAST  = MD_W'(1);

    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_MD  = 1'b1;

    localparam logic [1:0] SEL_GPR = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    logic [0:0]      state;
    logic [MD_W-1:0] md_cnt;

    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic load_use;
    logic branch_hz;
    logic hilo_hz;

    // A source hits a stage only if it is read, is not $zero, and the stage writes it.
    function automatic logic src_hit(input logic [4:0] src, input logic used,
                                     input logic wr, input logic [4:0] rd);
        return used && (src != 5'd0) && wr && (rd == src);
    endfunction

    // EX wins over MEM; a load in EX has no result yet, so it falls through to MEM/GPR.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic is_load);
        if (ex_hit && !is_load) begin
            return SEL_EX;
        end else if (mem_hit) begin
            return SEL_MEM;
        end
        return SEL_GPR;
    endfunction

    // Hazard detection and forward selection are purely combinational.
    always_comb begin
        ex_hit_a  = src_hit(id_rs, id_rs_used, ex_wr, ex_rd);
        ex_hit_b  = src_hit(id_rt, id_rt_used, ex_wr, ex_rd);
        mem_hit_a = src_hit(id_rs, id_rs_used, mem_wr, mem_rd);
        mem_hit_b = src_hit(id_rt, id_rt_used, mem_wr, mem_rd);

        fwd_a = fwd_sel(ex_hit_a, mem_hit_a, ex_load);
        fwd_b = fwd_sel(ex_hit_b, mem_hit_b, ex_load);

        // Branches resolve in decode, so any EX producer must move to MEM first.
        load_use  = ex_load && (ex_hit_a || ex_hit_b);
        branch_hz = id_branch && (ex_hit_a || ex_hit_b);
        hilo_hz   = id_hilo_use && md_busy;

        stall  = load_use || branch_hz || hilo_hz;
        bubble = stall;
    end

    assign md_busy = (state == S_MD);

    // MULT/DIV busy timer; md_done pulses in the cycle after the last busy cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_RUN;
            md_cnt  <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_RUN: begin
                    if (ex_md_start) begin
                        state  <= S_MD;
                        md_cnt <= ex_md_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                default: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MD_LAST;
                    end
                    if (md_cnt <= MD_LAST) begin
                        state   <= S_RUN;
                        md_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table for the combinational forwarding/stall
// logic plus hand-written sequences for the MULT/DIV timer, reset and counter.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             id_rs_used = 1'b0;
    logic             id_rt_used = 1'b0;
    logic             id_branch = 1'b0;
    logic             id_hilo_use = 1'b0;
    logic             ex_wr = 1'b0;
    logic [4:0]       ex_rd = '0;
    logic             ex_load = 1'b0;
    logic             ex_md_start = 1'b0;
    logic             ex_md_div = 1'b0;
    logic             mem_wr = 1'b0;
    logic [4:0]       mem_rd = '0;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch(id_branch), .id_hilo_use(id_hilo_use),
        .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       branch;
        logic       hilo;
        logic       ex_wr;
        logic [4:0] ex_rd;
        logic       ex_load;
        logic       mem_wr;
        logic [4:0] mem_rd;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic       e_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
        id_branch = 0; id_hilo_use = 0; ex_wr = 0; ex_rd = '0; ex_load = 0;
        ex_md_start = 0; ex_md_div = 0; mem_wr = 0; mem_rd = '0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Start a MULT/DIV with MFLO waiting in ID; count stall cycles and md_done pulses.
    task automatic md_run(input string name, input logic div, input int exp_cycles);
        int stalls;
        int pulses;
        int done_idx;
        stalls = 0; pulses = 0; done_idx = -1;
        clear_inputs();
        ex_md_start = 1'b1;
        ex_md_div   = div;
        id_hilo_use = 1'b1;
        #1;
        chk({name, "_stall_at_start"}, stall, 0);
        for (int i = 0; i < 60; i++) begin
            tick();
            ex_md_start = 1'b0;
            #1;
            if (stall) stalls++;
            if (md_done) begin
                pulses++;
                if (done_idx < 0) done_idx = i;
                chk({name, "_busy_at_done"}, md_busy, 0);
            end
        end
        chk({name, "_stall_cycles"}, stalls, exp_cycles);
        chk({name, "_done_pulses"}, pulses, 1);
        chk({name, "_done_cycle"}, done_idx, exp_cycles);
        id_hilo_use = 1'b0;
    endtask

    initial begin
        //          name          rs  rt  rsu rtu br hl exw exrd ld mw mrd  fa fb st
        vecs[0]  = '{"ex_fwd_a",   8,  0, 1,  0,  0, 0, 1,  8,   0, 0, 0,   1, 0, 0};
        vecs[1]  = '{"ex_beats_mem", 0, 8, 0, 1,  0, 0, 1,  8,   0, 1, 8,   0, 1, 0};
        vecs[2]  = '{"zero_reg",   0,  0, 0,  1,  0, 0, 1,  0,   0, 1, 0,   0, 0, 0};
        vecs[3]  = '{"mem_fwd_a",  5,  0, 1,  0,  0, 0, 0,  0,   0, 1, 5,   2, 0, 0};
        vecs[4]  = '{"load_use",   9,  0, 1,  0,  0, 0, 1,  9,   1, 0, 0,   0, 0, 1};
        vecs[5]  = '{"load_mem",   0,  9, 0,  1,  0, 0, 0,  0,   0, 1, 9,   0, 2, 0};
        vecs[6]  = '{"unused_src", 7,  7, 0,  0,  0, 0, 1,  7,   1, 1, 7,   0, 0, 0};
        vecs[7]  = '{"branch_ex",  3,  0, 1,  0,  1, 0, 1,  3,   0, 0, 0,   1, 0, 1};
        vecs[8]  = '{"branch_mem", 3,  0, 1,  0,  1, 0, 0,  0,   0, 1, 3,   2, 0, 0};
        vecs[9]  = '{"load_b_mem", 0,  4, 0,  1,  0, 0, 1,  4,   1, 1, 4,   0, 2, 1};
        vecs[10] = '{"hilo_idle",  0,  0, 0,  0,  0, 1, 0,  0,   0, 0, 0,   0, 0, 0};
        vecs[11] = '{"ex_nowrite", 6, 12, 1,  1,  0, 0, 0,  6,   0, 1, 12,  0, 2, 0};

        clear_inputs();
        do_reset();
        #1;
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Combinational vector table.
        for (int i = 0; i < 12; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
            id_branch = vecs[i].branch; id_hilo_use = vecs[i].hilo;
            ex_wr = vecs[i].ex_wr; ex_rd = vecs[i].ex_rd; ex_load = vecs[i].ex_load;
            mem_wr = vecs[i].mem_wr; mem_rd = vecs[i].mem_rd;
            #2;
            chk({vecs[i].name, "_fwd_a"}, fwd_a, vecs[i].e_fa);
            chk({vecs[i].name, "_fwd_b"}, fwd_b, vecs[i].e_fb);
            chk({vecs[i].name, "_stall"}, stall, vecs[i].e_stall);
            chk({vecs[i].name, "_bubble"}, bubble, vecs[i].e_stall);
            tick();
        end

        // Stall counter: counts, then saturates at 15.
        clear_inputs();
        do_reset();
        #1;
        chk("cnt_after_reset", stall_cnt, 0);
        ex_wr = 1; ex_rd = 9; ex_load = 1; id_rs = 9; id_rs_used = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("cnt_10", stall_cnt, 10);
        for (int i = 0; i < 9; i++) tick();
        chk("cnt_saturate", stall_cnt, 15);
        clear_inputs();
        tick();
        chk("cnt_hold", stall_cnt, 15);

        // DIV and MULT interlock lengths.
        do_reset();
        md_run("div", 1'b1, 32);
        md_run("mul", 1'b0, 5);

        // Reset in the middle of a divide aborts it with no md_done pulse.
        clear_inputs();
        do_reset();
        ex_md_start = 1; ex_md_div = 1;
        tick();
        ex_md_start = 0;
        for (int i = 0; i < 9; i++) tick();
        chk("middiv_busy_before", md_busy, 1);
        rst = 1'b0;
        tick();
        chk("middiv_busy_after_rst", md_busy, 0);
        chk("middiv_done_after_rst", md_done, 0);
        chk("middiv_cnt_after_rst", stall_cnt, 0);
        rst = 1'b1;
        id_hilo_use = 1'b1;
        begin
            int pulses;
            int busy_seen;
            pulses = 0; busy_seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (md_done) pulses++;
                if (md_busy) busy_seen++;
            end
            chk("middiv_no_done", pulses, 0);
            chk("middiv_no_busy", busy_seen, 0);
            chk("middiv_no_hilo_stall", stall_cnt, 0);
        end

        // Load-use and HI/LO hazard together give a single stall per cycle.
        clear_inputs();
        do_reset();
        ex_md_start = 1;
        ex_wr = 1; ex_rd = 2; ex_load = 1; id_rt = 2; id_rt_used = 1; id_hilo_use = 1;
        #1;
        chk("simul_start_stall", stall, 1);
        tick();
        ex_md_start = 0;
        #1;
        chk("simul_busy", md_busy, 1);
        chk("simul_stall", stall, 1);
        tick();
        tick();
        chk("simul_cnt", stall_cnt, 3);

        clear_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
